// File: rtl/peak_tracker_4b_pkg.sv
// Shared definitions for the windowed peak tracker.
// Holds the FSM state encoding and the default window geometry.
package peak_tracker_4b_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

   localparam int DEF_WIN   = 8;
   localparam int DEF_CNT_W = 4;

endpackage

// File: rtl/greater_than_4b.sv
// Unsigned 4-bit strict greater-than comparator.
// gt is high when i1 is strictly larger than i0.
module greater_than_4b (
   input  logic [3:0] i1,
   input  logic [3:0] i0,
   output logic       gt
);

   assign gt = (i1 > i0);

endmodule

// File: rtl/peak_tracker_4b.sv
// Windowed running-maximum tracker with valid/ready input and output.
// Reports the window maximum and the index of its first occurrence.
module peak_tracker_4b
   import peak_tracker_4b_pkg::*;
#(
   parameter int WIN   = DEF_WIN,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             in_valid,
   input  logic [3:0]       in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [3:0]       out_max,
   output logic [CNT_W-1:0] out_idx,
   input  logic             out_ready,
   output logic             busy
);

   // The counter must reach WIN-1 without wrapping inside a window.
   generate
      if (WIN < 2 || WIN > (1 << CNT_W)) begin : gWinCheck
         $error("peak_tracker_4b: WIN out of range for CNT_W");
      end
   endgenerate

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIN - 1);

   state_e           stateQ, stateD;
   logic [CNT_W-1:0] cntQ, cntD;
   logic [3:0]       maxQ, maxD;
   logic [CNT_W-1:0] idxQ, idxD;
   logic             newIsGreater;

   greater_than_4b uGt (
      .i1 (in_data),
      .i0 (maxQ),
      .gt (newIsGreater)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stateQ <= ST_IDLE;
         cntQ   <= '0;
         maxQ   <= '0;
         idxQ   <= '0;
      end else begin
         stateQ <= stateD;
         cntQ   <= cntD;
         maxQ   <= maxD;
         idxQ   <= idxD;
      end
   end

   // The first accept of a window loads unconditionally, so stale results never leak in.
   always_comb begin
      stateD    = stateQ;
      cntD      = cntQ;
      maxD      = maxQ;
      idxD      = idxQ;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (stateQ)
         ST_IDLE: begin
            if (start) begin
               stateD = ST_ACCUM;
               cntD   = '0;
            end
         end
         ST_ACCUM: begin
            in_ready = 1'b1;
            if (in_valid) begin
               cntD = cntQ + 1'b1;
               if (cntQ == '0) begin
                  maxD = in_data;
                  idxD = '0;
               end else if (newIsGreater) begin
                  maxD = in_data;
                  idxD = cntQ;
               end
               if (cntQ == LAST_CNT) begin
                  stateD = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               stateD = start ? ST_ACCUM : ST_IDLE;
               cntD   = '0;
            end
         end
         default: begin
            stateD = ST_IDLE;
         end
      endcase
   end

   assign out_max = maxQ;
   assign out_idx = idxQ;
   assign busy    = (stateQ != ST_IDLE);

endmodule
